can_tx_mailbox_sched: RTL and testbench
=======================================

Name: can_tx_mailbox_sched

Overview:
Transmit scheduler in front of the bit-stuffing CAN transmitter (tx_container). It holds NUM_MB transmit mailboxes loaded by the host. When the transmitter is idle, it picks the pending mailbox with the lowest (highest-priority) CAN ID and presents that ID and payload. It then pulses the send strobe, tracks the transmitter's busy flag through the frame, and retires the mailbox or re-queues it.

Parameters:
NUM_MB, 4, number of transmit mailboxes (2..8)
START_TMO, 64, clk cycles allowed between send pulse and tx_busy rising
RETRY_MAX, 8, max re-queues per mailbox after arbitration loss (RETRY_LIMIT_EN only)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
mb_wr  in  1  load strobe; writes mb_id/mb_data into mailbox mb_sel and marks it pending
mb_sel  in  clog2(NUM_MB)  target mailbox for mb_wr/mb_abort
mb_id  in  11  CAN identifier
mb_data  in  64  frame payload
mb_abort  in  1  clears the pending flag of mb_sel if that mailbox is not in flight
mb_pending  out  NUM_MB  per-mailbox pending flags
mb_done  out  NUM_MB  one-cycle pulse per mailbox on successful completion
mb_err  out  NUM_MB  one-cycle pulse per mailbox on start timeout (or retry exhaustion)
tx_address  out  11  ID to transmitter, registered
tx_data  out  64  payload to transmitter, registered
tx_send  out  1  one-cycle send strobe to transmitter
tx_busy  in  1  transmitter txing flag
arb_lost  in  1  arbitration-loss pulse from bus monitor; tie 0 if unused
sched_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all pending flags 0, mb_done/mb_err 0, tx_send 0, tx_address 0, tx_data 0, state IDLE, counters 0.
- FSM states: IDLE, SELECT, LAUNCH, WAIT_START, WAIT_END.
  - IDLE: if any pending bit is set and tx_busy=0, go to SELECT.
  - SELECT (1 cycle): find the pending mailbox with minimum mb_id; on equal IDs, the lowest index wins. Latch index cur, and register tx_address/tx_data from that mailbox. Go to LAUNCH.
  - LAUNCH: drive tx_send=1 for exactly one cycle; clear the start counter; go to WAIT_START.
  - WAIT_START: tx_busy=1 goes to WAIT_END. When the counter reaches START_TMO-1 with tx_busy still 0: pulse mb_err[cur], clear pending[cur], go to IDLE.
  - WAIT_END: arb_lost=1 leaves pending[cur] set (re-queue) and waits for tx_busy=0 before going to IDLE. When tx_busy falls with no loss recorded: pulse mb_done[cur], clear pending[cur], go to IDLE.
- Latency: mb_wr into an idle scheduler gives tx_send asserted 3 cycles later (IDLE, SELECT, LAUNCH).
- tx_address/tx_data stay stable from SELECT until the next SELECT.
- Mailbox writes:
  - mb_wr to a mailbox not in flight is always accepted.
  - mb_wr to cur while in LAUNCH/WAIT_* is ignored; its contents and pending flag are unchanged.
  - mb_wr and mb_abort in the same cycle: mb_wr wins.
- mb_abort:
  - On the in-flight mailbox it is ignored.
  - On a non-pending mailbox it is a no-op.
- Simultaneous events on the same cycle: completion clear takes priority over a new write to a different mailbox. Both take effect, since they touch different entries.
- arb_lost outside WAIT_END is ignored.
- Asynchronous reset mid-frame returns to IDLE immediately with all mailboxes cleared. tx_send is never re-issued for a cleared frame.

Optional Feature:
RETRY_LIMIT_EN
- Defined: each mailbox has a retry counter (width clog2(RETRY_MAX+1)).
  - The counter is cleared on mb_wr and incremented on each arb_lost re-queue.
  - When it would exceed RETRY_MAX: pulse mb_err[cur] and clear pending[cur] instead of re-queuing.
- Undefined: unlimited re-queues, no retry counters.

Decomposition:
- Shared package can_pkg:
  - CAN_ID_W=11 and CAN_DATA_W=64.
  - State encoding constants S_IDLE..S_WAIT_END.
- One sub-module can_id_prio_sel: combinational minimum-ID finder.
  - Inputs: pending mask and NUM_MB IDs.
  - Outputs: winning index and valid.
  - Tie goes to the lowest index.

Test Plan:
- Load mb0 id=0x123 and mb1 id=0x045 in the same idle window; emulate tx_busy -> tx_address=0x045 first, mb_done[1] pulses, then id 0x123 is sent and mb_done[0] pulses.
- mb_wr to mb2 (id=0x7FF, data=64'hDEADBEEF_CAFEF00D) -> tx_send exactly 1 cycle high 3 cycles after mb_wr; tx_data matches.
- Hold tx_busy=0 after tx_send -> mb_err pulses after 64 cycles; the pending bit clears; sched_busy drops.
- Pulse arb_lost during WAIT_END for id 0x100 -> pending is kept and the frame relaunches after tx_busy falls. With RETRY_LIMIT_EN, the 9th loss produces an mb_err pulse.
- mb_abort on a queued mailbox while another is in flight -> its pending bit clears and it is never sent. mb_abort on the in-flight mailbox is ignored and mb_done still pulses.
- Assert rst during WAIT_END with 3 mailboxes pending -> all outputs are 0 next cycle and no tx_send occurs after rst release.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN scheduler definitions: field widths and scheduler state encoding.
package can_pkg;

    localparam int CAN_ID_W   = 11;
    localparam int CAN_DATA_W = 64;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SELECT     = 3'd1,
        S_LAUNCH     = 3'd2,
        S_WAIT_START = 3'd3,
        S_WAIT_END   = 3'd4
    } can_state_e;

endpackage

// File: rtl/can_id_prio_sel.sv
// Combinational minimum-ID finder over the pending mailboxes; ties go to the lowest index.
module can_id_prio_sel
    import can_pkg::*;
#(
    parameter int NUM_MB = 4,
    localparam int IDX_W = $clog2(NUM_MB)
) (
    input  logic [NUM_MB-1:0]          pending_i,
    input  logic [NUM_MB*CAN_ID_W-1:0] ids_i,
    output logic [IDX_W-1:0]           idx_o,
    output logic                       valid_o
);

    logic [CAN_ID_W-1:0] best;
    logic [CAN_ID_W-1:0] cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        best    = '0;
        cand    = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            cand = ids_i[i*CAN_ID_W +: CAN_ID_W];
            // Strict compare keeps the earlier (lower) index on equal IDs.
            if (pending_i[i] && (!valid_o || cand < best)) begin
                valid_o = 1'b1;
                best    = cand;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/can_tx_mailbox_sched.sv
// CAN transmit mailbox scheduler: launches the lowest-ID pending mailbox into tx_container.
// Optional RETRY_LIMIT_EN bounds arbitration-loss re-queues per mailbox to RETRY_MAX.
module can_tx_mailbox_sched
    import can_pkg::*;
#(
    parameter int NUM_MB    = 4,
    parameter int START_TMO = 64,
    parameter int RETRY_MAX = 8,
    localparam int IDX_W    = $clog2(NUM_MB)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mb_wr,
    input  logic [IDX_W-1:0]      mb_sel,
    input  logic [CAN_ID_W-1:0]   mb_id,
    input  logic [CAN_DATA_W-1:0] mb_data,
    input  logic                  mb_abort,
    output logic [NUM_MB-1:0]     mb_pending,
    output logic [NUM_MB-1:0]     mb_done,
    output logic [NUM_MB-1:0]     mb_err,
    output logic [CAN_ID_W-1:0]   tx_address,
    output logic [CAN_DATA_W-1:0] tx_data,
    output logic                  tx_send,
    input  logic                  tx_busy,
    input  logic                  arb_lost,
    output logic                  sched_busy,
    output can_state_e            state_dbg
);

    localparam int CNT_W = $clog2(START_TMO + 1);

    if (NUM_MB < 2 || NUM_MB > 8 || START_TMO < 2 || RETRY_MAX < 1) begin : g_param_check
        $error("can_tx_mailbox_sched: parameter out of range");
    end

    can_state_e            state_q, state_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  lost_q, lost_d;
    logic [NUM_MB-1:0]     pending_q, pending_d;
    logic [NUM_MB-1:0]     done_q, done_d;
    logic [NUM_MB-1:0]     err_q, err_d;
    logic [CAN_ID_W-1:0]   addr_q, addr_d;
    logic [CAN_DATA_W-1:0] txd_q, txd_d;
    logic [CAN_ID_W-1:0]   id_q   [NUM_MB];
    logic [CAN_DATA_W-1:0] data_q [NUM_MB];

    logic [NUM_MB*CAN_ID_W-1:0] ids_flat;
    logic [IDX_W-1:0]           sel_idx;
    logic                       sel_valid;
    logic                       in_flight_sel;
    logic                       wr_ok;

`ifdef RETRY_LIMIT_EN
    localparam int RT_W = $clog2(RETRY_MAX + 1);
    logic [RT_W-1:0] retry_q [NUM_MB];
    logic [RT_W-1:0] retry_d [NUM_MB];
`endif

    always_comb begin
        ids_flat = '0;
        for (int i = 0; i < NUM_MB; i++) ids_flat[i*CAN_ID_W +: CAN_ID_W] = id_q[i];
    end

    can_id_prio_sel #(.NUM_MB(NUM_MB)) u_prio_sel (
        .pending_i (pending_q),
        .ids_i     (ids_flat),
        .idx_o     (sel_idx),
        .valid_o   (sel_valid)
    );

    // Host access to the launched mailbox is locked out until it is retired or re-queued.
    assign in_flight_sel = (state_q inside {S_LAUNCH, S_WAIT_START, S_WAIT_END}) && (mb_sel == cur_q);
    assign wr_ok         = mb_wr && !in_flight_sel;

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        lost_d    = lost_q;
        pending_d = pending_q;
        done_d    = '0;
        err_d     = '0;
        addr_d    = addr_q;
        txd_d     = txd_q;
`ifdef RETRY_LIMIT_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            S_IDLE: if (|pending_q && !tx_busy) state_d = S_SELECT;
            S_SELECT: begin
                if (sel_valid) begin
                    cur_d   = sel_idx;
                    addr_d  = id_q[sel_idx];
                    txd_d   = data_q[sel_idx];
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                lost_d  = 1'b0;
                state_d = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (tx_busy) begin
                    state_d = S_WAIT_END;
                end else if (cnt_q == CNT_W'(START_TMO - 1)) begin
                    err_d[cur_q]     = 1'b1;
                    pending_d[cur_q] = 1'b0;
                    state_d          = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_END: begin
                if (arb_lost) lost_d = 1'b1;
                if (!tx_busy) begin
                    state_d = S_IDLE;
                    if (lost_q || arb_lost) begin
`ifdef RETRY_LIMIT_EN
                        if (retry_q[cur_q] == RT_W'(RETRY_MAX)) begin
                            err_d[cur_q]     = 1'b1;
                            pending_d[cur_q] = 1'b0;
                        end else begin
                            retry_d[cur_q] = retry_q[cur_q] + 1'b1;
                        end
`endif
                    end else begin
                        done_d[cur_q]    = 1'b1;
                        pending_d[cur_q] = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Host ops never target cur while it is in flight, so they cannot collide with retirement.
        if (wr_ok) begin
            pending_d[mb_sel] = 1'b1;
`ifdef RETRY_LIMIT_EN
            retry_d[mb_sel]   = '0;
`endif
        end else if (mb_abort && !in_flight_sel) begin
            pending_d[mb_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            cnt_q     <= '0;
            lost_q    <= 1'b0;
            pending_q <= '0;
            done_q    <= '0;
            err_q     <= '0;
            addr_q    <= '0;
            txd_q     <= '0;
            for (int i = 0; i < NUM_MB; i++) begin
                id_q[i]    <= '0;
                data_q[i]  <= '0;
`ifdef RETRY_LIMIT_EN
                retry_q[i] <= '0;
`endif
            end
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            lost_q    <= lost_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            txd_q     <= txd_d;
            if (wr_ok) begin
                id_q[mb_sel]   <= mb_id;
                data_q[mb_sel] <= mb_data;
            end
`ifdef RETRY_LIMIT_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign mb_pending = pending_q;
    assign mb_done    = done_q;
    assign mb_err     = err_q;
    assign tx_address = addr_q;
    assign tx_data    = txd_q;
    assign tx_send    = (state_q == S_LAUNCH);
    assign sched_busy = (state_q != S_IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_can_tx_mailbox_sched.sv
// Scoreboard bench for can_tx_mailbox_sched: stimulus pushes expected send/done/err events,
// a negedge monitor pops and compares them. Define RETRY_LIMIT_EN to exercise the retry limit.
module tb_can_tx_mailbox_sched;
  import can_pkg::*;

  localparam int NUM_MB = 4;
  localparam int EV_W   = 80;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mb_wr = 1'b0;
  logic [1:0]        mb_sel = '0;
  logic [10:0]       mb_id = '0;
  logic [63:0]       mb_data = '0;
  logic              mb_abort = 1'b0;
  logic [NUM_MB-1:0] mb_pending, mb_done, mb_err;
  logic [10:0]       tx_address;
  logic [63:0]       tx_data;
  logic              tx_send;
  logic              tx_busy = 1'b0;
  logic              arb_lost = 1'b0;
  logic              sched_busy;
  can_state_e        state_dbg;

  logic [EV_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int sends_seen = 0;
  int sends_waited = 0;

  can_tx_mailbox_sched #(.NUM_MB(NUM_MB), .START_TMO(64), .RETRY_MAX(8)) dut (
    .clk(clk), .rst(rst), .mb_wr(mb_wr), .mb_sel(mb_sel), .mb_id(mb_id), .mb_data(mb_data),
    .mb_abort(mb_abort), .mb_pending(mb_pending), .mb_done(mb_done), .mb_err(mb_err),
    .tx_address(tx_address), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .arb_lost(arb_lost), .sched_busy(sched_busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [EV_W-1:0] ev_send(input logic [10:0] id, input logic [63:0] d);
    return {2'd0, 3'd0, id, d};
  endfunction

  function automatic logic [EV_W-1:0] ev_stat(input logic [1:0] t, input int idx);
    return {t, 3'(idx), 75'd0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // scoreboard
  task automatic sb_check(input string name, input logic [EV_W-1:0] got);
    logic [EV_W-1:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s unexpected: got %h, expected no event", name, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s: got %h, expected %h", name, got, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_send) begin
        sends_seen++;
        sb_check("tx_send", ev_send(tx_address, tx_data));
      end
      for (int i = 0; i < NUM_MB; i++) begin
        if (mb_done[i]) sb_check("mb_done", ev_stat(2'd1, i));
        if (mb_err[i])  sb_check("mb_err", ev_stat(2'd2, i));
      end
    end
  end

  // driver tasks (all start and end at posedge+1)
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int sel, input logic [10:0] id, input logic [63:0] d, input bit ab);
    mb_wr = 1'b1; mb_abort = ab; mb_sel = sel[1:0]; mb_id = id; mb_data = d;
    step();
    mb_wr = 1'b0; mb_abort = 1'b0;
  endtask

  task automatic abort_mb(input int sel);
    mb_abort = 1'b1; mb_sel = sel[1:0];
    step();
    mb_abort = 1'b0;
  endtask

  task automatic wait_send();
    int target = sends_waited + 1;
    int t = 0;
    while (sends_seen < target && t < 300) begin
      @(negedge clk); t++;
    end
    chk("wait_send_timeout", 64'(sends_seen >= target), 64'd1);
    sends_waited = target;
    step();
  endtask

  task automatic frame(input bit lose);
    tx_busy = 1'b1;
    repeat (4) step();
    if (lose) begin
      arb_lost = 1'b1; step(); arb_lost = 1'b0;
    end
    step();
    tx_busy = 1'b0;
    step(); step();
  endtask

  initial begin : watchdog
    #2ms;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : stim
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pending", 64'(mb_pending), 64'd0);
    chk("rst_tx_send", 64'(tx_send), 64'd0);
    chk("rst_tx_address", 64'(tx_address), 64'd0);
    chk("rst_tx_data", tx_data, 64'd0);
    chk("rst_sched_busy", 64'(sched_busy), 64'd0);
    chk("rst_done_err", 64'({mb_done, mb_err}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    step();

    // lowest ID first, then the other
    exp_q.push_back(ev_send(11'h045, 64'h1111_0000_0000_0045));
    exp_q.push_back(ev_stat(2'd1, 1));
    exp_q.push_back(ev_send(11'h123, 64'h0000_0000_0000_0123));
    exp_q.push_back(ev_stat(2'd1, 0));
    wr(0, 11'h123, 64'h0000_0000_0000_0123, 1'b0);
    wr(1, 11'h045, 64'h1111_0000_0000_0045, 1'b0);
    chk("pending_two", 64'(mb_pending), 64'b0011);
    wait_send(); frame(1'b0);
    wait_send(); frame(1'b0);
    chk("pending_empty1", 64'(mb_pending), 64'd0);

    // send latency and strobe width
    exp_q.push_back(ev_send(11'h7FF, 64'hDEADBEEF_CAFEF00D));
    exp_q.push_back(ev_stat(2'd1, 2));
    mb_wr = 1'b1; mb_sel = 2'd2; mb_id = 11'h7FF; mb_data = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    chk("send_early", 64'(tx_send), 64'd0);
    @(posedge clk); #1 mb_wr = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!tx_send && k < 20);
    chk("send_latency", 64'(k), 64'd3);
    @(negedge clk);
    chk("send_width", 64'(tx_send), 64'd0);
    sends_waited++;
    step();
    frame(1'b0);

    // start timeout: err 65 cycles after the launch cycle (64 WAIT_START cycles, then retire)
    exp_q.push_back(ev_send(11'h200, 64'h0000_0000_0000_0200));
    exp_q.push_back(ev_stat(2'd2, 3));
    wr(3, 11'h200, 64'h0000_0000_0000_0200, 1'b0);
    k = 0;
    while (!tx_send && k < 20) begin @(negedge clk); k++; end
    sends_waited++;
    k = 0;
    do begin @(negedge clk); k++; end while (!mb_err[3] && k < 200);
    chk("tmo_latency", 64'(k), 64'd65);
    chk("tmo_pending", 64'(mb_pending[3]), 64'd0);
    chk("tmo_sched_busy", 64'(sched_busy), 64'd0);
    step();

    // arbitration loss re-queue
`ifdef RETRY_LIMIT_EN
    for (int i = 0; i < 9; i++) exp_q.push_back(ev_send(11'h100, 64'h0000_0000_0000_0100));
    exp_q.push_back(ev_stat(2'd2, 0));
    wr(0, 11'h100, 64'h0000_0000_0000_0100, 1'b0);
    for (int i = 0; i < 9; i++) begin
      wait_send(); frame(1'b1);
      if (i == 0) chk("arb_requeue", 64'(mb_pending[0]), 64'd1);
    end
    chk("retry_exhausted", 64'(mb_pending[0]), 64'd0);
`else
    exp_q.push_back(ev_send(11'h100, 64'h0000_0000_0000_0100));
    exp_q.push_back(ev_send(11'h100, 64'h0000_0000_0000_0100));
    exp_q.push_back(ev_stat(2'd1, 0));
    wr(0, 11'h100, 64'h0000_0000_0000_0100, 1'b0);
    wait_send(); frame(1'b1);
    chk("arb_requeue", 64'(mb_pending[0]), 64'd1);
    wait_send(); frame(1'b0);
    chk("arb_retired", 64'(mb_pending[0]), 64'd0);
`endif

    // abort / write lockout on the in-flight mailbox, wr beats abort
    exp_q.push_back(ev_send(11'h010, 64'h0000_0000_0000_0010));
    exp_q.push_back(ev_stat(2'd1, 1));
    exp_q.push_back(ev_send(11'h030, 64'h0000_0000_0000_0030));
    exp_q.push_back(ev_stat(2'd1, 3));
    wr(1, 11'h010, 64'h0000_0000_0000_0010, 1'b0);
    wait_send();
    wr(2, 11'h020, 64'h0000_0000_0000_0020, 1'b0);
    chk("queued_pending", 64'(mb_pending[2]), 64'd1);
    abort_mb(2);
    chk("abort_queued", 64'(mb_pending[2]), 64'd0);
    abort_mb(1);
    chk("abort_inflight", 64'(mb_pending[1]), 64'd1);
    wr(1, 11'h7AA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wr(3, 11'h030, 64'h0000_0000_0000_0030, 1'b1);
    chk("wr_beats_abort", 64'(mb_pending[3]), 64'd1);
    chk("tx_addr_stable", 64'(tx_address), 64'h010);
    frame(1'b0);
    wait_send(); frame(1'b0);
    repeat (10) step();
    chk("pending_empty2", 64'(mb_pending), 64'd0);

    // async reset mid-frame
    exp_q.push_back(ev_send(11'h300, 64'h0000_0000_0000_0300));
    wr(0, 11'h300, 64'h0000_0000_0000_0300, 1'b0);
    wr(1, 11'h301, 64'h0000_0000_0000_0301, 1'b0);
    wr(2, 11'h302, 64'h0000_0000_0000_0302, 1'b0);
    wait_send();
    tx_busy = 1'b1;
    repeat (3) step();
    chk("pre_rst_pending", 64'(mb_pending), 64'b0111);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_pending", 64'(mb_pending), 64'd0);
    chk("mid_rst_busy", 64'(sched_busy), 64'd0);
    chk("mid_rst_addr", 64'(tx_address), 64'd0);
    chk("mid_rst_data", tx_data, 64'd0);
    chk("mid_rst_send", 64'(tx_send), 64'd0);
    @(posedge clk); #1 rst = 1'b0; tx_busy = 1'b0;
    repeat (30) step();
    chk("post_rst_sends", 64'(sends_seen), 64'(sends_waited));

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
